// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state type and constants for the pipeline hazard controller
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } pipe_state_t;

  localparam int REG_AW_DEF = 5;
  localparam int WAIT_CNT_W = 8;

endpackage

// File: rtl/pipe_perf_cnt.sv
// rtl/pipe_perf_cnt.sv - 32-bit saturating event counter with increment enable
module pipe_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_inc,
  output logic [31:0] o_count
);

  logic [31:0] r_count;

  // count enabled cycles, holding at all-ones once reached
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != 32'hFFFF_FFFF)) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer; PIPE_PERF_CNT_EN enables the perf counters
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int REG_AW      = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_rs1_used,
  input  logic              i_id_rs2_used,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_ex_mem_read,
  input  logic              i_pc_sel,
  input  logic              i_npc_op,
  input  logic              i_dmem_req,
  input  logic              i_dmem_ack,
  output logic              o_pc_en,
  output logic              o_if_id_en,
  output logic              o_id_ex_en,
  output logic              o_ex_mem_en,
  output logic              o_if_id_flush,
  output logic              o_id_ex_flush,
  output logic              o_mem_wb_flush,
  output logic              o_mem_err,
  output logic [31:0]       o_stall_cycles,
  output logic [31:0]       o_flush_count
);

  localparam logic [WAIT_CNT_W:0] LP_TIMEOUT = (WAIT_CNT_W + 1)'(MEM_TIMEOUT);

  pipe_state_t           r_state;
  pipe_state_t           w_state_nxt;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic [WAIT_CNT_W:0]   w_wait_inc;
  logic                  w_freeze;
  logic                  w_load_use;
  logic                  w_redirect;

  assign w_load_use = i_ex_mem_read && (i_ex_rd != '0) &&
                      ((i_id_rs1_used && (i_id_rs1 == i_ex_rd)) ||
                       (i_id_rs2_used && (i_id_rs2 == i_ex_rd)));
  assign w_redirect = i_pc_sel || i_npc_op;
  assign w_wait_inc = {1'b0, r_wait_cnt} + {{WAIT_CNT_W{1'b0}}, 1'b1};
  assign o_mem_err  = (r_state == ERR);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // wait counter: counts unacknowledged WAIT cycles, zero everywhere else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if ((r_state == WAIT) && !i_dmem_ack) begin
      r_wait_cnt <= r_wait_cnt + {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // next state and per-stage controls; reset forces the pass-through pattern
  always_comb begin
    w_state_nxt    = r_state;
    w_freeze       = 1'b0;
    o_pc_en        = 1'b1;
    o_if_id_en     = 1'b1;
    o_id_ex_en     = 1'b1;
    o_ex_mem_en    = 1'b1;
    o_if_id_flush  = 1'b0;
    o_id_ex_flush  = 1'b0;
    o_mem_wb_flush = 1'b0;

    case (r_state)
      RUN: begin
        if (i_dmem_req && !i_dmem_ack) begin
          w_freeze    = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (i_dmem_ack) begin
          w_state_nxt = RUN;
        end else begin
          w_freeze = 1'b1;
          if (w_wait_inc >= LP_TIMEOUT) begin
            w_state_nxt = ERR;
          end
        end
      end
      ERR: begin
        w_freeze = 1'b1;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase

    if (!rst) begin
      if (w_freeze) begin
        // hold every stage and bubble WB so no write retires twice
        o_pc_en        = 1'b0;
        o_if_id_en     = 1'b0;
        o_id_ex_en     = 1'b0;
        o_ex_mem_en    = 1'b0;
        o_mem_wb_flush = 1'b1;
      end else if (w_redirect) begin
        // the ID instruction is discarded, so a load-use match is moot
        o_if_id_flush = 1'b1;
        o_id_ex_flush = 1'b1;
      end else if (w_load_use) begin
        o_pc_en       = 1'b0;
        o_if_id_en    = 1'b0;
        o_id_ex_flush = 1'b1;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  pipe_perf_cnt u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (!o_pc_en),
    .o_count (o_stall_cycles)
  );

  pipe_perf_cnt u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (o_if_id_flush),
    .o_count (o_flush_count)
  );
`else
  assign o_stall_cycles = 32'd0;
  assign o_flush_count  = 32'd0;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It combines load-use hazard detection, control-redirect flushing (`pc_sel`/`npc_op`) and a data-memory wait state machine with timeout. Its outputs are the per-stage enable/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It replaces ad-hoc flush generation and is the single owner of all pipeline-register control signals.

## Interface
- `MEM_TIMEOUT`, 64: maximum consecutive wait cycles for a data-memory access before the error state; legal range 2..255.
- `REG_AW`, 5: register-address width.
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `id_rs1`, `id_rs2`  in  REG_AW  source registers of the instruction in ID.
- `id_rs1_used`, `id_rs2_used`  in  1  the ID instruction actually reads that source.
- `ex_rd`  in  REG_AW  destination of the instruction in EX.
- `ex_mem_read`  in  1  the instruction in EX is a load.
- `pc_sel`, `npc_op`  in  1  redirect request from EX (branch taken / jump).
- `dmem_req`  in  1  MEM stage is issuing a data-memory access this cycle.
- `dmem_ack`  in  1  data memory completes the access this cycle.
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`  out  1  register load enables.
- `if_id_flush`, `id_ex_flush`, `mem_wb_flush`  out  1  load a bubble (NOP) instead of stage data.
- `mem_err`  out  1  sticky memory-timeout error.
- `stall_cycles`, `flush_count`  out  32  performance counters (see Configuration).

## Operation
- FSM states: RUN, WAIT, ERR. Reset state is RUN.
- **RUN**
  - If `dmem_req && !dmem_ack`: freeze this cycle and go to WAIT.
  - Otherwise apply the redirect and load-use rules below.
- **WAIT**
  - Freeze while `!dmem_ack`.
  - On `dmem_ack`: unfreeze in the same cycle, apply the redirect and load-use rules, then go to RUN.
  - The wait counter increments on each WAIT cycle without ack.
  - When the counter reaches `MEM_TIMEOUT` with no ack, go to ERR.
- **ERR**
  - Permanent freeze with `mem_err`=1. Exit only by reset.
- **Freeze**
  - `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en` = 0.
  - `mem_wb_flush`=1, so WB never repeats a write.
  - All other flushes = 0; a redirect raised during freeze is ignored until unfreeze.
- **Load-use**
  - Condition: `ex_mem_read && ex_rd!=0 && ((id_rs1_used && id_rs1==ex_rd) || (id_rs2_used && id_rs2==ex_rd))`.
  - Response: `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1; other enables = 1.
- **Redirect** (`pc_sel || npc_op`)
  - `if_id_flush`=1, `id_ex_flush`=1, all enables = 1.
  - Redirect overrides load-use: the ID instruction is discarded anyway.
- Priority: ERR > freeze > redirect > load-use > normal (all enables 1, all flushes 0).
- The wait counter is cleared on entry to WAIT and in RUN; width is 8 bits.

## Timing
- All control outputs are combinational (Mealy) from state and inputs. A stall or flush takes effect on the same rising edge as the hazard cycle.
- Load-use costs exactly 1 bubble cycle. On the next cycle, `ex_mem_read` is 0 because the EX stage holds the bubble.
- Memory wait of N cycles (ack on cycle N+1 after the request) freezes the pipeline for exactly N cycles.
- Ack in the request cycle causes no stall and no state change.
- Reset values: state RUN, counters 0, `mem_err`=0. Outputs in reset: all enables 1, all flushes 0.
- Reset asserted mid-WAIT or in ERR returns immediately to RUN.

## Configuration
- `PIPE_PERF_CNT_EN` defined: the performance counters are live.
  - `stall_cycles` increments on every cycle with `pc_en`=0.
  - `flush_count` increments on every cycle with `if_id_flush`=1.
  - Both counters saturate at 0xFFFF_FFFF and are cleared by reset.
- `PIPE_PERF_CNT_EN` undefined: both outputs are tied to 0 and no counter flops are inferred.

## Structure
- Shared package `pipe_pkg` holds:
  - the state enum (RUN/WAIT/ERR);
  - `REG_AW_DEF`=5;
  - the wait-counter width constant.
- One sub-module: `pipe_perf_cnt`, a single 32-bit saturating counter with increment enable, instantiated twice inside the `PIPE_PERF_CNT_EN` guard.

## Test plan
- Load `x5` in EX and `id_rs1`=5 with `id_rs1_used`=1 → one cycle with `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1; normal on the next cycle. Same case with `ex_rd`=0 → no stall.
- `pc_sel`=1 in the same cycle as a load-use match → `if_id_flush`=1, `id_ex_flush`=1, `pc_en`=1; `flush_count` increments by 1.
- `dmem_req`=1 with ack 3 cycles later → freeze for exactly 3 cycles with `mem_wb_flush`=1; ack cycle is normal; `stall_cycles`=3.
- `MEM_TIMEOUT`=4 with no ack → ERR after 4 WAIT cycles; `mem_err`=1 and the freeze hold indefinitely; asserting `rst` returns to RUN with `mem_err`=0.
- `npc_op`=1 raised during WAIT → no flush while frozen; flush appears in the ack cycle.
- `rst` asserted mid-WAIT (asynchronous, off-edge) → outputs return to reset values immediately; counters = 0.
